// File: rtl/l1_axi_responder.sv
// l1_axi_responder: AXI-style 32-bit slave backed by a local word-addressed SRAM.
// Serves single-beat and INCR-burst reads and single-beat strobed writes. A host
// preload port initialises the SRAM and takes priority over AXI writes.

module l1_axi_responder #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter logic [1:0]  ERR_RESP   = 2'b10
) (
  input  logic                  clk,
  input  logic                  rstn,

  // Write address channel
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [31:0]           s_awaddr,
  input  logic [7:0]            s_awlen,
  input  logic [2:0]            s_awsize,

  // Write data channel
  input  logic                  s_wvalid,
  output logic                  s_wready,
  input  logic [31:0]           s_wdata,
  input  logic [3:0]            s_wstrb,
  input  logic                  s_wlast,

  // Write response channel
  output logic                  s_bvalid,
  input  logic                  s_bready,
  output logic [1:0]            s_bresp,
  output logic                  s_bid,

  // Read address channel
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic [31:0]           s_araddr,
  input  logic [7:0]            s_arlen,
  input  logic [2:0]            s_arsize,

  // Read data channel
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [31:0]           s_rdata,
  output logic                  s_rlast,
  output logic [1:0]            s_rresp,
  output logic                  s_rid,

  // Host preload port
  input  logic                  init_we,
  input  logic [DEPTH_LOG2-1:0] init_addr,
  input  logic [31:0]           init_data
);

  localparam int unsigned Words = 1 << DEPTH_LOG2;
  // First byte-address bit above the SRAM; anything set from here up is out of range.
  localparam int unsigned HiBit = DEPTH_LOG2 + 2;

  typedef enum logic [1:0] {RIdle, RFetch, RData} r_state_e;
  typedef enum logic       {WIdle, WResp}         w_state_e;

  // Word storage; never reset so contents survive rstn.
  logic [31:0] mem [Words];

  // ---------------------------------------------------------------------------
  // Read channel state
  // ---------------------------------------------------------------------------
  r_state_e              r_state_q;
  logic [31:0]           r_addr_q;
  logic [8:0]            r_cnt_q;     // beats remaining, 1..256
  logic                  arready_q;
  logic                  rvalid_q;
  logic                  rlast_q;
  logic [31:0]           rdata_q;
  logic [1:0]            rresp_q;

  logic [DEPTH_LOG2-1:0] r_idx;
  logic                  r_in_range;

  assign r_idx      = r_addr_q[DEPTH_LOG2+1:2];
  assign r_in_range = (r_addr_q >> HiBit) == 32'd0;

  // ---------------------------------------------------------------------------
  // Write channel state
  // ---------------------------------------------------------------------------
  w_state_e              w_state_q;
  logic                  w_open_q;    // idle and out of reset: AW+W may be taken
  logic                  bvalid_q;
  logic [1:0]            bresp_q;

  logic                  w_hs;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_in_range;

  // AW and W are only ever accepted together, and never while the host preloads.
  assign w_hs       = (w_state_q == WIdle) & w_open_q & s_awvalid & s_wvalid & ~init_we;
  assign w_idx      = s_awaddr[DEPTH_LOG2+1:2];
  assign w_in_range = (s_awaddr >> HiBit) == 32'd0;

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s_awready = w_hs;
  assign s_wready  = w_hs;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_bid     = 1'b0;

  assign s_arready = arready_q;
  assign s_rvalid  = rvalid_q;
  assign s_rdata   = rdata_q;
  assign s_rlast   = rlast_q;
  assign s_rresp   = rresp_q;
  assign s_rid     = 1'b0;

  // Beat size and WLAST carry no information here: every beat is a full word
  // and writes are always single-beat.
  logic unused_inputs;
  assign unused_inputs = ^{s_awsize, s_arsize, s_wlast};

  // ---------------------------------------------------------------------------
  // SRAM write port: host preload wins, otherwise strobed AXI write when in range
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= init_data;
    end else if (w_hs && w_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (s_wstrb[b]) begin
          mem[w_idx][8*b +: 8] <= s_wdata[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM: accept AR, then alternate fetch / present per beat
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state_q <= RIdle;
      r_addr_q  <= 32'd0;
      r_cnt_q   <= 9'd0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= 32'd0;
      rresp_q   <= 2'b00;
    end else begin
      unique case (r_state_q)
        RIdle: begin
          arready_q <= 1'b1;
          if (arready_q && s_arvalid) begin
            r_addr_q  <= s_araddr;
            r_cnt_q   <= {1'b0, s_arlen} + 9'd1;
            arready_q <= 1'b0;
            r_state_q <= RFetch;
          end
        end
        RFetch: begin
          // Range is judged per beat so a burst may run off the end of the SRAM.
          // The array read sees pre-write contents on a same-word collision.
          rdata_q   <= r_in_range ? mem[r_idx] : 32'd0;
          rresp_q   <= r_in_range ? 2'b00 : ERR_RESP;
          rlast_q   <= (r_cnt_q == 9'd1);
          rvalid_q  <= 1'b1;
          r_state_q <= RData;
        end
        RData: begin
          // rdata_q is only loaded in RFetch, so it holds while the master stalls.
          if (s_rready) begin
            rvalid_q <= 1'b0;
            if (rlast_q) begin
              arready_q <= 1'b1;
              r_state_q <= RIdle;
            end else begin
              r_addr_q  <= r_addr_q + 32'd4;
              r_cnt_q   <= r_cnt_q - 9'd1;
              r_state_q <= RFetch;
            end
          end
        end
        default: begin
          r_state_q <= RIdle;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write FSM: joint AW+W acceptance, then hold B until the master takes it
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_state_q <= WIdle;
      w_open_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      unique case (w_state_q)
        WIdle: begin
          w_open_q <= 1'b1;
          if (w_hs) begin
            // Bursts are flagged as errors but beat 0 has still been written.
            w_open_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= (w_in_range && (s_awlen == 8'd0)) ? 2'b00 : ERR_RESP;
            w_state_q <= WResp;
          end
        end
        WResp: begin
          if (s_bready) begin
            bvalid_q  <= 1'b0;
            w_open_q  <= 1'b1;
            w_state_q <= WIdle;
          end
        end
        default: begin
          w_state_q <= WIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/l1_axi_responder.md
Name: l1_axi_responder

Overview:
- AXI-style 32-bit slave that terminates an application core's m_axi_l1 master port, backed by a local word-addressed SRAM.
- Serves single-beat and INCR-burst reads (ARLEN 0..255) and single-beat strobed writes.
- A host preload port initialises the SRAM. Used as the memory model and as a standalone scratchpad for per-core app tiles.

Parameters:
- DEPTH_LOG2, 12, log2 of SRAM depth in 32-bit words; byte address space is 4*2^DEPTH_LOG2.
- ERR_RESP, 2'b10, RRESP/BRESP code for out-of-range accesses.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- s_awvalid  in  1  write address valid
- s_awready  out  1  write address ready
- s_awaddr  in  32  write byte address
- s_awlen  in  8  write burst length-1
- s_awsize  in  3  write beat size
- s_wvalid  in  1  write data valid
- s_wready  out  1  write data ready
- s_wdata  in  32  write data
- s_wstrb  in  4  byte strobes
- s_wlast  in  1  last write beat
- s_bvalid  out  1  write response valid
- s_bready  in  1  write response ready
- s_bresp  out  2  write response
- s_bid  out  1  constant 0
- s_arvalid  in  1  read address valid
- s_arready  out  1  read address ready
- s_araddr  in  32  read byte address
- s_arlen  in  8  read burst length-1
- s_arsize  in  3  read beat size
- s_rvalid  out  1  read data valid
- s_rready  in  1  read data ready
- s_rdata  out  32  read data
- s_rlast  out  1  last read beat
- s_rresp  out  2  read response
- s_rid  out  1  constant 0
- init_we  in  1  host preload write enable
- init_addr  in  DEPTH_LOG2  host preload word index
- init_data  in  32  host preload data (full word)

Behaviour:
- Reset: clk is the clock; rstn is synchronous and active-low. All valid/ready outputs are 0 at reset. s_rdata, s_rresp and s_bresp reset to 0. Read FSM resets to R_IDLE, write FSM to W_IDLE. SRAM contents are not reset.
- Addressing: word index = addr[DEPTH_LOG2+1:2]. addr[1:0] is ignored. In range iff addr[31:DEPTH_LOG2+2]==0. AxSIZE is ignored; every beat is 32 bits.
- Read FSM, states R_IDLE, R_FETCH, R_DATA:
  - R_IDLE: s_arready=1. On s_arvalid, latch addr and beat count = arlen+1, then go to R_FETCH.
  - R_FETCH: issue SRAM read of the current word, then go to R_DATA.
  - R_DATA: s_rvalid=1. s_rdata is the SRAM output, held stable while s_rready=0. s_rlast=1 when remaining count==1.
  - Out-of-range beat: s_rdata=0 and s_rresp=ERR_RESP; otherwise s_rresp=0.
  - On s_rready in R_DATA: if last, go to R_IDLE; else addr+=4, count-=1, go to R_FETCH.
  - Throughput is 1 beat per 2 cycles with no backpressure. AR-to-first-RVALID latency is 2 cycles.
  - Each beat's range is checked independently, so a burst can run past the end of the SRAM. 4KB boundary crossing is not checked.
- Write FSM, states W_IDLE, W_RESP:
  - Joint handshake: s_awready = s_wready = (W_IDLE & s_awvalid & s_wvalid & ~init_we). Both readies assert in the same cycle only; a lone AWVALID or a lone WVALID is never accepted.
  - On handshake, write the SRAM bytes selected by s_wstrb (in range only), then go to W_RESP.
  - W_RESP: s_bvalid=1. s_bresp=0, or ERR_RESP if the address was out of range or s_awlen!=0 (the write is still performed for beat 0). s_wlast is ignored.
  - On s_bready, go to W_IDLE. The next write is accepted no earlier than the cycle after B completes.
- Read and write channels are independent and concurrent.
- SRAM has one read port and one write port. A same-cycle read and write to the same word returns old data (read-first).
- init_we writes the full word the same cycle and has priority over AXI writes: AXI write readies are held low while init_we=1. AXI reads are unaffected.
- rstn asserted mid-burst or with BVALID pending: outstanding transactions are dropped, outputs return to reset values the next cycle, SRAM contents are kept.

Test Plan:
- Preload word3=0x40, word4=0x80, word5=0xC0. Three single reads of 0xC, 0x10, 0x14 -> RDATA 0x40, 0x80, 0xC0. RLAST=1 and RRESP=0 on each. Each RVALID appears 2 cycles after the AR handshake.
- Preload words 0x20..0x23 = 0xA0..0xA3. Read araddr=0x80, arlen=3, with RREADY toggling 1,0,0,1... -> 4 beats 0xA0..0xA3 in order. RDATA held stable while stalled. RLAST only on 0xA3.
- Word 7 = 0x11223344. Write awaddr=0x1C, wdata=0xAABBCCDD, wstrb=4'b0101 -> BVALID with BRESP=0. A read of 0x1C returns 0x11BB33DD.
- AWVALID only for 5 cycles, then WVALID joins -> AWREADY/WREADY stay 0 until both are valid, then pulse together for exactly 1 cycle. BVALID is held until BREADY.
- DEPTH_LOG2=12. Read araddr=0x4000 -> RDATA=0, RRESP=2'b10. Write to 0x4000 -> BRESP=2'b10 and no SRAM change. Burst araddr=0x3FFC, arlen=1 -> beat0 RRESP=0, beat1 RRESP=2'b10.
- init_we=1 in the same cycle as a valid AW+W -> AXI readies are 0 that cycle, the init write lands, and the AXI write is accepted the next cycle. Reset asserted mid-burst -> RVALID=0 the next cycle, and a new AR is accepted after reset is released.
